// File: rtl/ans_cdf_table_if.sv
// Signal bundle for ans_cdf_table: count loading, forward CDF lookup and
// reverse slot-to-symbol lookup channels, plus the synchronous clear.
interface ans_cdf_table_if;
  localparam int unsigned SYM_W = 4;
  localparam int unsigned CUM_W = 8;

  logic             clear;
  logic [SYM_W-1:0] cnt_in;
  logic             cnt_vld;
  logic             cnt_rdy;
  logic [SYM_W-1:0] q_sym;
  logic [SYM_W-1:0] s_count;
  logic [CUM_W-1:0] s_cumulative;
  logic [CUM_W-1:0] total_count;
  logic             tbl_valid;
  logic             tbl_err;
  logic [CUM_W-1:0] slot;
  logic             slot_vld;
  logic             slot_rdy;
  logic [SYM_W-1:0] res_sym;
  logic             res_oob;
  logic             res_vld;
  logic             res_rdy;

  modport slave (
    input  clear, cnt_in, cnt_vld, q_sym, slot, slot_vld, res_rdy,
    output cnt_rdy, s_count, s_cumulative, total_count, tbl_valid, tbl_err,
           slot_rdy, res_sym, res_oob, res_vld
  );

  modport master (
    output clear, cnt_in, cnt_vld, q_sym, slot, slot_vld, res_rdy,
    input  cnt_rdy, s_count, s_cumulative, total_count, tbl_valid, tbl_err,
           slot_rdy, res_sym, res_oob, res_vld
  );
endinterface

// File: rtl/ans_cdf_table.sv
// 16-symbol ANS frequency table: loads counts, builds cumulative sums, serves
// forward lookups; reverse slot lookup is present only with ANS_CDF_REVLOOKUP_EN.
module ans_cdf_table (
  input  logic            clk,
  input  logic            rst,
  ans_cdf_table_if.slave  bus
);
  localparam int unsigned SYM_W = 4;
  localparam int unsigned CUM_W = 8;
  localparam int unsigned N_SYM = 16;
  localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(N_SYM - 1);

  typedef enum logic [1:0] {LOAD, BUILD, READY, SCAN} state_t;

  state_t           state, state_next;
  logic [SYM_W-1:0] idx;
  logic [SYM_W-1:0] count [N_SYM];
  logic [CUM_W-1:0] cum   [N_SYM];
  logic [CUM_W-1:0] run_sum;
  logic [CUM_W-1:0] total;
  logic             tbl_valid;
  logic             tbl_err;
  logic [CUM_W-1:0] build_sum_c;
  logic             load_fire_c;
  logic             build_last_c;

  assign build_sum_c = run_sum + CUM_W'(count[idx]);

`ifdef ANS_CDF_REVLOOKUP_EN
  logic [CUM_W-1:0] slot_q;
  logic [SYM_W-1:0] sidx;
  logic             res_vld;
  logic             res_oob;
  logic [SYM_W-1:0] res_sym;
  logic             slot_fire_c;
  logic             scan_oob_c;
  logic             scan_hit_c;

  assign bus.slot_rdy = (state == READY) && tbl_valid && !res_vld;
  assign slot_fire_c  = bus.slot_vld && bus.slot_rdy;
  assign scan_oob_c   = (slot_q >= total);
  // Interval test; cum + count stays <= 240 so the 8-bit add cannot wrap
  assign scan_hit_c   = (count[sidx] != '0) && (slot_q >= cum[sidx]) &&
                        (slot_q < (cum[sidx] + CUM_W'(count[sidx])));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_next   = state;
    load_fire_c  = 1'b0;
    build_last_c = 1'b0;
    if (bus.clear) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (bus.cnt_vld) begin
            load_fire_c = 1'b1;
            if (idx == LAST_IDX) state_next = BUILD;
          end
        end
        BUILD: begin
          if (idx == LAST_IDX) begin
            build_last_c = 1'b1;
            state_next   = READY;
          end
        end
`ifdef ANS_CDF_REVLOOKUP_EN
        READY: begin
          if (slot_fire_c) state_next = SCAN;
        end
        SCAN: begin
          if (scan_oob_c || scan_hit_c || (sidx == LAST_IDX)) state_next = READY;
        end
`else
        READY: state_next = READY;
`endif
        default: state_next = LOAD;
      endcase
    end
  end

  // Count storage and cumulative build; idx wraps 15->0 into BUILD and again into READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      run_sum   <= '0;
      total     <= '0;
      tbl_valid <= 1'b0;
      tbl_err   <= 1'b0;
      count     <= '{default: '0};
      cum       <= '{default: '0};
    end else if (bus.clear) begin
      idx       <= '0;
      run_sum   <= '0;
      tbl_valid <= 1'b0;
      tbl_err   <= 1'b0;
    end else begin
      if (load_fire_c) begin
        count[idx] <= bus.cnt_in;
        idx        <= idx + SYM_W'(1);
        run_sum    <= '0;
      end
      if (state == BUILD) begin
        cum[idx] <= run_sum;
        run_sum  <= build_sum_c;
        idx      <= idx + SYM_W'(1);
        if (build_last_c) begin
          total     <= build_sum_c;
          tbl_valid <= (build_sum_c != '0);
          tbl_err   <= (build_sum_c == '0);
        end
      end
    end
  end

`ifdef ANS_CDF_REVLOOKUP_EN
  // Reverse lookup: first SCAN cycle also resolves the out-of-range case
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= '0;
      sidx    <= '0;
      res_vld <= 1'b0;
      res_oob <= 1'b0;
      res_sym <= '0;
    end else if (bus.clear) begin
      sidx    <= '0;
      res_vld <= 1'b0;
      res_oob <= 1'b0;
      res_sym <= '0;
    end else begin
      if (res_vld && bus.res_rdy) res_vld <= 1'b0;
      if (slot_fire_c) begin
        slot_q <= bus.slot;
        sidx   <= '0;
      end
      if (state == SCAN) begin
        sidx <= sidx + SYM_W'(1);
        if (scan_oob_c || (!scan_hit_c && (sidx == LAST_IDX))) begin
          res_vld <= 1'b1;
          res_oob <= 1'b1;
          res_sym <= '0;
        end else if (scan_hit_c) begin
          res_vld <= 1'b1;
          res_oob <= 1'b0;
          res_sym <= sidx;
        end
      end
    end
  end

  assign bus.res_vld = res_vld;
  assign bus.res_oob = res_oob;
  assign bus.res_sym = res_sym;
`else
  logic unused_rev;
  assign unused_rev   = ^{bus.slot, bus.slot_vld, bus.res_rdy};
  assign bus.slot_rdy = 1'b0;
  assign bus.res_vld  = 1'b0;
  assign bus.res_oob  = 1'b0;
  assign bus.res_sym  = '0;
`endif

  assign bus.cnt_rdy      = (state == LOAD);
  assign bus.s_count      = count[bus.q_sym];
  assign bus.s_cumulative = cum[bus.q_sym];
  assign bus.total_count  = total;
  assign bus.tbl_valid    = tbl_valid;
  assign bus.tbl_err      = tbl_err;
endmodule

// File: doc/ans_cdf_table.md
ANS_CDF_TABLE -- requirements
Module: ans_cdf_table

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 clear  in  1  synchronous pulse: discard table, return to LOAD.
REQ-004 cnt_in  in  4  per-symbol count, presented in symbol order 0..15.
REQ-005 cnt_vld / cnt_rdy  in / out  1 / 1  valid/ready handshake for cnt_in.
REQ-006 q_sym  in  4  symbol to look up for the encoder.
REQ-007 s_count  out  4  count[q_sym], combinational from registers.
REQ-008 s_cumulative  out  8  cum[q_sym] = sum of count[0..q_sym-1], combinational.
REQ-009 total_count  out  8  sum of all 16 counts; maximum 240.
REQ-010 tbl_valid / tbl_err  out / out  1 / 1  table usable / table built with total 0.
REQ-011 slot, slot_vld / slot_rdy  in, in / out  8, 1 / 1  reverse-lookup request for the decoder.
REQ-012 res_sym, res_oob, res_vld / res_rdy  out, out, out / in  4, 1, 1 / 1  reverse-lookup result.

Function
REQ-013 FSM states: LOAD, BUILD, READY, SCAN.
- LOAD: cnt_rdy=1. Each cnt_vld&&cnt_rdy stores count[idx] and increments a 4-bit idx.
- Transfer at idx=15 moves to BUILD.
REQ-014 BUILD: one symbol per cycle, cum[i]=running sum, running sum += count[i].
- 16 cycles total; on the last cycle total_count is registered and the FSM goes to READY.
- cnt_rdy=0 throughout BUILD.
REQ-015 Entering READY: tbl_valid=1 if total!=0; otherwise tbl_err=1 and tbl_valid=0.
REQ-016 Lookup outputs are don't-care while tbl_valid=0.
- s_count, s_cumulative and total_count shall not change in READY or SCAN.
REQ-017 Sums use 8-bit unsigned arithmetic; 16x15=240 never overflows.
REQ-018 slot_rdy=1 only in READY with tbl_valid=1 and no result pending (res_vld=0).
- Handshake latches slot and enters SCAN at i=0.
REQ-019 SCAN checks one symbol per cycle: match when count[i]!=0 and cum[i] <= slot < cum[i]+count[i].
- On match: res_sym=i, res_oob=0, res_vld=1, return to READY.
- Result is valid i+1 cycles after the handshake.
REQ-020 slot >= total_count: res_oob=1, res_sym=0, res_vld=1.
- Result valid the cycle after the handshake; no scan is performed.
REQ-021 res_vld and the result shall stay stable until res_rdy; res_vld clears on the res_rdy cycle.
- A new slot can be accepted the cycle after res_vld clears.
REQ-022 clear has priority over all handshakes in any state.
- Next state LOAD, idx=0; tbl_valid, tbl_err and res_vld clear.
- Any in-flight scan or pending result is dropped.
REQ-023 cnt_vld outside LOAD is ignored; slot_vld outside READY is ignored.

Reset
REQ-024 rst asynchronously forces:
- state LOAD, idx=0, cnt_rdy=1;
- tbl_valid=0, tbl_err=0, res_vld=0, res_oob=0, res_sym=0, slot_rdy=0;
- total_count=0, all count and cum entries 0.
REQ-025 Reset deassertion mid-operation: the block restarts from LOAD; no partial table survives.

Configuration
REQ-026 Macro ANS_CDF_REVLOOKUP_EN.
- Defined: SCAN state, slot/res logic per REQ-018..021.
- Undefined: no SCAN hardware; slot_rdy=0, res_vld=0, res_sym=0, res_oob=0 constantly.
- The forward lookup is identical in both builds.

Verification
REQ-027 Load count[i]=1 for all i, wait 16 BUILD cycles -> tbl_valid=1, total_count=16, q_sym=5 gives s_count=1, s_cumulative=5.
REQ-028 Load count[i]=i -> total_count=120, q_sym=15 gives s_cumulative=105, q_sym=0 gives s_count=0, s_cumulative=0.
REQ-029 Load all zeros -> tbl_err=1, tbl_valid=0, slot_rdy=0.
REQ-030 Counts all 1, slot=7 -> res_sym=7, res_oob=0, res_vld 8 cycles after handshake; hold res_rdy=0 for 3 cycles -> result stable.
REQ-031 Counts count[i]=i, slot=120 -> res_oob=1 one cycle after handshake; slot=0 -> res_sym=1 (symbol 0 skipped).
REQ-032 clear in BUILD cycle 7, then in SCAN -> next cycle LOAD, cnt_rdy=1, tbl_valid=0, res_vld never asserts.
